branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised successor to the decode-stage branch/jump target adder.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters for fetch-side prediction.
- Resolves B/JAL/JALR in the execute stage: computes actual outcome and target, detects mispredictions, issues a registered redirect, updates the BTB, and keeps saturating performance counters.

Parameters:
- XLEN, 32, datapath/PC width.
- BTB_ENTRIES, 16, BTB depth; power of two, at least 2; IDX_W = log2(BTB_ENTRIES).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_pc  in  XLEN  fetch PC to look up.
- pred_taken  out  1  combinational: BTB predicts taken for if_pc.
- pred_target  out  XLEN  combinational: predicted target; equals if_pc+4 when pred_taken=0.
- ex_valid  in  1  execute slot holds a real instruction.
- ex_stall  in  1  execute stage held; suppresses resolution.
- ex_instr  in  32  instruction in execute.
- ex_pc  in  XLEN  PC of the execute instruction.
- ex_rs1  in  XLEN  rs1 operand, forwarded.
- ex_rs2  in  XLEN  rs2 operand, forwarded.
- ex_pred_taken  in  1  pred_taken carried down the pipe with this instruction.
- ex_pred_target  in  XLEN  pred_target carried down the pipe.
- redirect_valid  out  1  registered one-cycle pulse: mispredict, refetch required.
- redirect_pc  out  XLEN  registered correct next PC.
- branch_cnt  out  CNT_W  resolved B/JAL/JALR count; saturates at all-ones.
- mispredict_cnt  out  CNT_W  mispredict count; saturates at all-ones.

Behaviour:
- Reset (async, rst=1): all BTB entries invalid, counters cleared to 2'b00; redirect_valid=0, redirect_pc=0, branch_cnt=0, mispredict_cnt=0.
- Reset mid-operation: any pending redirect is dropped. No BTB write takes effect in a cycle where rst is high.
- BTB entry fields: valid, tag = pc[XLEN-1:IDX_W+2], target[XLEN-1:0], ctr[1:0], jmp (JAL/JALR).
- BTB index = pc[IDX_W+1:2].
- Lookup (combinational): hit = valid && tag match.
  - pred_taken = hit && (jmp || ctr[1]).
  - pred_target = pred_taken ? entry.target : if_pc+4, modulo 2^XLEN.
- A resolve event is ex_valid && !ex_stall && opcode in {B, JAL, JALR}. Other opcodes have no effect.
- Branch compare uses RISC-V semantics:
  - BEQ: rs1==rs2. BNE: rs1!=rs2.
  - BLT: signed rs1<rs2. BGE: signed rs1>=rs2.
  - BLTU: unsigned rs1<rs2. BGEU: unsigned rs1>=rs2.
  - funct3 010/011: treated as not taken, still counted as a branch.
- Actual target (wraps modulo 2^XLEN):
  - B: ex_pc + sign-extended B-immediate.
  - JAL: ex_pc + sign-extended J-immediate.
  - JALR: (rs1 + sign-extended I-immediate) with bit 0 forced to 0.
  - JAL/JALR are always taken.
- Next PC = taken ? target : ex_pc+4.
- Mispredict = (taken != ex_pred_taken) || (taken && target != ex_pred_target).
- Redirect timing: on a resolve event with mispredict, redirect_valid=1 and redirect_pc=next PC on the following edge, for exactly one cycle. Otherwise redirect_valid=0 next cycle. While ex_stall=1, redirect_valid=0.
- BTB update, on the resolve edge:
  - Hit at ex_pc: target <= actual target if taken; ctr saturating ++ if taken, -- if not taken; jmp <= opcode!=B.
  - Miss and taken: allocate (overwrite slot): valid=1, new tag, target, ctr=2'b10, jmp as above.
  - Miss and not taken: no write.
- Same-cycle lookup and update of the same index: lookup returns pre-update contents; no bypass.
- Counters: branch_cnt +1 per resolve event; mispredict_cnt +1 per mispredicted resolve event. Both hold at all-ones.

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104; all outputs 0.
- JAL at ex_pc=0x100 with imm=+0x40, ex_pred_taken=0 -> next cycle redirect_valid=1, redirect_pc=0x140, mispredict_cnt=1. Afterwards if_pc=0x100 -> pred_taken=1, pred_target=0x140.
- BLT, rs1=0xFFFFFFFF, rs2=1, imm=-8, ex_pc=0x200, pred not-taken -> taken, redirect_pc=0x1F8. Same operands as BLTU -> not taken, no redirect.
- BEQ at 0x300 resolved taken twice, then not-taken with pred_taken=1 -> redirect_pc=0x304; ctr goes 10->11->10, so the next lookup still predicts taken.
- JALR rs1=0x1001, imm=+2, correct predicted target 0x1002 -> no redirect, branch_cnt increments. Same with ex_stall=1 -> no redirect, no counter change, no BTB write.
- Assert rst during the cycle a redirect would register -> redirect_valid stays 0 and the BTB stays empty.

Source files
------------

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: BTB-based fetch prediction with execute-stage branch resolution, redirect and perf counters
module branch_predict_unit #(
  parameter int XLEN = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic [31:0]     ex_instr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  logic             btb_v   [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_tgt [BTB_ENTRIES];
  logic [1:0]       btb_ctr [BTB_ENTRIES];
  logic             btb_jmp [BTB_ENTRIES];
  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             f_hit, e_hit;
  logic [6:0]       opc;
  logic [2:0]       f3;
  logic             is_b, is_jal, is_jalr, resolve;
  logic [XLEN-1:0]  imm_b, imm_j, imm_i, target, next_pc;
  logic             eq, lt, ltu, cond, taken, mispredict;
  logic [1:0]       ctr_next;
  assign f_idx = if_pc[IDX_W+1:2];
  assign f_hit = btb_v[f_idx] && btb_tag[f_idx] == if_pc[XLEN-1:IDX_W+2];
  assign pred_taken = f_hit && (btb_jmp[f_idx] || btb_ctr[f_idx][1]);
  assign pred_target = pred_taken ? btb_tgt[f_idx] : if_pc + XLEN'(4);
  assign opc = ex_instr[6:0];
  assign f3 = ex_instr[14:12];
  assign is_b = opc == 7'b1100011;
  assign is_jal = opc == 7'b1101111;
  assign is_jalr = opc == 7'b1100111;
  assign resolve = ex_valid && !ex_stall && (is_b || is_jal || is_jalr);
  assign imm_b = {{(XLEN-12){ex_instr[31]}}, ex_instr[7], ex_instr[30:25], ex_instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){ex_instr[31]}}, ex_instr[19:12], ex_instr[20], ex_instr[30:21], 1'b0};
  assign imm_i = {{(XLEN-11){ex_instr[31]}}, ex_instr[30:20]};
  assign eq = ex_rs1 == ex_rs2;
  assign lt = $signed(ex_rs1) < $signed(ex_rs2);
  assign ltu = ex_rs1 < ex_rs2;
  assign cond = f3 == 3'b000 ? eq : f3 == 3'b001 ? !eq : f3 == 3'b100 ? lt :
                f3 == 3'b101 ? !lt : f3 == 3'b110 ? ltu : f3 == 3'b111 ? !ltu : 1'b0;
  assign taken = is_b ? cond : 1'b1;
  assign target = is_jalr ? (ex_rs1 + imm_i) & ~XLEN'(1) : ex_pc + (is_b ? imm_b : imm_j);
  assign next_pc = taken ? target : ex_pc + XLEN'(4);
  assign mispredict = taken != ex_pred_taken || (taken && target != ex_pred_target);
  assign e_idx = ex_pc[IDX_W+1:2];
  assign e_tag = ex_pc[XLEN-1:IDX_W+2];
  assign e_hit = btb_v[e_idx] && btb_tag[e_idx] == e_tag;
  assign ctr_next = taken ? (btb_ctr[e_idx] == 2'b11 ? 2'b11 : btb_ctr[e_idx] + 2'd1)
                          : (btb_ctr[e_idx] == 2'b00 ? 2'b00 : btb_ctr[e_idx] - 2'd1);
  // BTB training: refresh hits, allocate on taken misses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_v[i] <= 1'b0;
        btb_tag[i] <= '0;
        btb_tgt[i] <= '0;
        btb_ctr[i] <= 2'b00;
        btb_jmp[i] <= 1'b0;
      end
    end else if (resolve && e_hit) begin
      if (taken) btb_tgt[e_idx] <= target;
      btb_ctr[e_idx] <= ctr_next;
      btb_jmp[e_idx] <= !is_b;
    end else if (resolve && taken) begin
      btb_v[e_idx] <= 1'b1;
      btb_tag[e_idx] <= e_tag;
      btb_tgt[e_idx] <= target;
      btb_ctr[e_idx] <= 2'b10;
      btb_jmp[e_idx] <= !is_b;
    end
  end
  // One-cycle redirect pulse carrying the corrected PC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect_valid <= resolve && mispredict;
      if (resolve && mispredict) redirect_pc <= next_pc;
    end
  end
  // Saturating resolve and mispredict counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (resolve && !(&branch_cnt)) branch_cnt <= branch_cnt + CNT_W'(1);
      if (resolve && mispredict && !(&mispredict_cnt)) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed stimulus with a behavioural BTB/resolve model checked every cycle
module tb_branch_predict_unit;
  localparam int CW = 4;
  localparam int MAXC = 15;
  logic clk = 0;
  logic rst;
  logic [31:0] if_pc, ex_instr, ex_pc, ex_rs1, ex_rs2, ex_pred_target;
  logic ex_valid, ex_stall, ex_pred_taken;
  logic pred_taken, redirect_valid;
  logic [31:0] pred_target, redirect_pc;
  logic [CW-1:0] branch_cnt, mispredict_cnt;
  int checks = 0;
  int errors = 0;
  int cur_kind;
  logic [2:0] cur_f3;
  int cur_imm;
  bit m_v [16];
  int unsigned m_tag [16];
  logic [31:0] m_tgt [16];
  int m_ctr [16];
  bit m_jmp [16];
  logic m_rv;
  logic [31:0] m_rpc;
  int m_bc, m_mc;
  logic c_tk;
  logic [31:0] c_tg;

  branch_predict_unit #(.XLEN(32), .BTB_ENTRIES(16), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_instr(ex_instr), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input int imm);
    logic [12:0] v;
    v = imm[12:0];
    return {v[12], v[10:5], 5'd2, 5'd1, f3, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(input int imm);
    logic [20:0] v;
    v = imm[20:0];
    return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input int imm);
    logic [11:0] v;
    v = imm[11:0];
    return {v, 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  task automatic m_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    int i;
    i = (pc / 4) % 16;
    tk = m_v[i] && m_tag[i] == pc / 64 && (m_jmp[i] || m_ctr[i] >= 2);
    tg = tk ? m_tgt[i] : pc + 4;
  endtask

  // Reference model: what each resolved instruction must do, from the ISA rules
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_v[i] = 0;
        m_ctr[i] = 0;
      end
      m_rv = 0;
      m_rpc = 0;
      m_bc = 0;
      m_mc = 0;
    end else begin
      m_rv = 0;
      if (ex_valid && !ex_stall && cur_kind != 0) begin
        logic tk, mis;
        logic [31:0] tg, nx;
        int i;
        if (cur_kind == 1) begin
          case (cur_f3)
            3'd0: tk = ex_rs1 == ex_rs2;
            3'd1: tk = ex_rs1 != ex_rs2;
            3'd4: tk = $signed(ex_rs1) < $signed(ex_rs2);
            3'd5: tk = $signed(ex_rs1) >= $signed(ex_rs2);
            3'd6: tk = ex_rs1 < ex_rs2;
            3'd7: tk = ex_rs1 >= ex_rs2;
            default: tk = 0;
          endcase
          tg = ex_pc + 32'(cur_imm);
        end else begin
          tk = 1;
          tg = cur_kind == 2 ? ex_pc + 32'(cur_imm) : (ex_rs1 + 32'(cur_imm)) & 32'hFFFF_FFFE;
        end
        nx = tk ? tg : ex_pc + 4;
        mis = tk != ex_pred_taken || (tk && tg != ex_pred_target);
        m_rv = mis;
        if (mis) m_rpc = nx;
        if (m_bc < MAXC) m_bc++;
        if (mis && m_mc < MAXC) m_mc++;
        i = (ex_pc / 4) % 16;
        if (m_v[i] && m_tag[i] == ex_pc / 64) begin
          if (tk) m_tgt[i] = tg;
          m_ctr[i] = tk ? (m_ctr[i] < 3 ? m_ctr[i] + 1 : 3) : (m_ctr[i] > 0 ? m_ctr[i] - 1 : 0);
          m_jmp[i] = cur_kind != 1;
        end else if (tk) begin
          m_v[i] = 1;
          m_tag[i] = ex_pc / 64;
          m_tgt[i] = tg;
          m_ctr[i] = 2;
          m_jmp[i] = cur_kind != 1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    m_lookup(if_pc, c_tk, c_tg);
    chk("pred_taken", 32'(pred_taken), 32'(c_tk));
    chk("pred_target", pred_target, c_tg);
    chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
    chk("branch_cnt", 32'(branch_cnt), 32'(m_bc));
    chk("mispredict_cnt", 32'(mispredict_cnt), 32'(m_mc));
  end

  task automatic set_ex(input int kind, input logic [2:0] f3, input int imm, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic pt,
                        input logic [31:0] ptg, input logic stall);
    cur_kind = kind;
    cur_f3 = f3;
    cur_imm = imm;
    ex_pc = pc;
    ex_rs1 = rs1;
    ex_rs2 = rs2;
    ex_pred_taken = pt;
    ex_pred_target = ptg;
    ex_stall = stall;
    ex_instr = kind == 1 ? enc_b(f3, imm) : kind == 2 ? enc_jal(imm) : kind == 3 ? enc_jalr(imm) : 32'h0050_0093;
    ex_valid = 1;
  endtask

  task automatic drv(input int kind, input logic [2:0] f3, input int imm, input logic [31:0] pc,
                     input logic [31:0] rs1, input logic [31:0] rs2, input logic pt,
                     input logic [31:0] ptg, input logic stall);
    set_ex(kind, f3, imm, pc, rs1, rs2, pt, ptg, stall);
    @(posedge clk);
    #1;
    ex_valid = 0;
    ex_stall = 0;
    cur_kind = 0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    if_pc = pc;
    #1;
    chk({name, "_taken"}, 32'(pred_taken), 32'(tk));
    chk({name, "_target"}, pred_target, tg);
  endtask

  initial begin
    rst = 1;
    if_pc = 32'h100;
    ex_valid = 0;
    ex_stall = 0;
    ex_instr = 0;
    ex_pc = 0;
    ex_rs1 = 0;
    ex_rs2 = 0;
    ex_pred_taken = 0;
    ex_pred_target = 0;
    cur_kind = 0;
    cur_f3 = 0;
    cur_imm = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    look("reset_lookup", 32'h100, 0, 32'h104);
    chk("reset_rv", 32'(redirect_valid), 0);
    chk("reset_rpc", redirect_pc, 0);
    chk("reset_bc", 32'(branch_cnt), 0);
    chk("reset_mc", 32'(mispredict_cnt), 0);
    drv(2, 0, 32'h40, 32'h100, 0, 0, 0, 32'h104, 0);
    chk("jal_rv", 32'(redirect_valid), 1);
    chk("jal_rpc", redirect_pc, 32'h140);
    chk("jal_mc", 32'(mispredict_cnt), 1);
    chk("jal_bc", 32'(branch_cnt), 1);
    look("jal_lookup", 32'h100, 1, 32'h140);
    @(posedge clk);
    #1;
    chk("pulse_drop", 32'(redirect_valid), 0);
    drv(1, 3'd4, -8, 32'h200, 32'hFFFF_FFFF, 1, 0, 32'h204, 0);
    chk("blt_rv", 32'(redirect_valid), 1);
    chk("blt_rpc", redirect_pc, 32'h1F8);
    drv(1, 3'd6, -8, 32'h200, 32'hFFFF_FFFF, 1, 0, 32'h204, 0);
    chk("bltu_rv", 32'(redirect_valid), 0);
    drv(1, 3'd0, 32'h20, 32'h300, 5, 5, 0, 32'h304, 0);
    chk("beq1_rpc", redirect_pc, 32'h320);
    drv(1, 3'd0, 32'h20, 32'h300, 5, 5, 1, 32'h320, 0);
    chk("beq2_rv", 32'(redirect_valid), 0);
    drv(1, 3'd0, 32'h20, 32'h300, 5, 6, 1, 32'h320, 0);
    chk("beq3_rv", 32'(redirect_valid), 1);
    chk("beq3_rpc", redirect_pc, 32'h304);
    look("beq_lookup", 32'h300, 1, 32'h320);
    drv(3, 0, 2, 32'h400, 32'h1001, 0, 1, 32'h1002, 0);
    chk("jalr_rv", 32'(redirect_valid), 0);
    chk("jalr_bc", 32'(branch_cnt), 7);
    drv(3, 0, 2, 32'h484, 32'h1001, 0, 0, 32'h488, 1);
    chk("stall_rv", 32'(redirect_valid), 0);
    chk("stall_bc", 32'(branch_cnt), 7);
    look("stall_lookup", 32'h484, 0, 32'h488);
    drv(0, 0, 0, 32'h4C0, 0, 0, 1, 32'h9999, 0);
    chk("other_bc", 32'(branch_cnt), 7);
    drv(1, 3'd2, 32'h10, 32'h508, 0, 0, 1, 32'h518, 0);
    chk("f3_010_rpc", redirect_pc, 32'h50C);
    set_ex(2, 0, 32'h80, 32'h108, 0, 0, 0, 32'h10C, 0);
    #2;
    rst = 1;
    @(posedge clk);
    #1;
    chk("rstmid_rv", 32'(redirect_valid), 0);
    chk("rstmid_bc", 32'(branch_cnt), 0);
    ex_valid = 0;
    cur_kind = 0;
    rst = 0;
    look("rstmid_lookup", 32'h108, 0, 32'h10C);
    look("rstmid_lookup2", 32'h300, 0, 32'h304);
    for (int k = 0; k < 18; k++) drv(2, 0, 32'h20, 32'h600 + 32'(k * 4), 0, 0, 0, 0, 0);
    chk("sat_bc", 32'(branch_cnt), 15);
    chk("sat_mc", 32'(mispredict_cnt), 15);
    for (int k = 0; k < 4; k++) drv(1, 3'd1, 32'h40, 32'h700, k, 0, 1, 32'h740, 0);
    chk("sat_hold_bc", 32'(branch_cnt), 15);
    look("bne_lookup", 32'h700, 1, 32'h740);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
